// File: rtl/probe_pkg.sv
// Shared types and constants for the probe frame sequencer.
// The phase encoding is also the value driven on the debug phase port.
package probe_pkg;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SQUARE = 2'd1,
        PH_DATA   = 2'd2,
        PH_GAP    = 2'd3
    } phase_t;

    localparam logic [6:0] PRBS7_SEED = 7'h7F;
    localparam int PRBS7_TAP_HI = 6;
    localparam int PRBS7_TAP_LO = 5;

    localparam int DEF_HALF_PERIOD = 1;
    localparam int DEF_BURST_LEN   = 16;
    localparam int DEF_GAP_LEN     = 16;

endpackage

// File: rtl/prbs7_gen.sv
// PRBS7 (x^7+x^6+1) generator with synchronous reload to the seed.
// o_bit_out is the bit presented after the coming edge, for registering.
module prbs7_gen
    import probe_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_advance,
    output logic o_bit_out
);

    logic [6:0] r_lfsr;
    logic [6:0] w_lfsr_nxt;

    always_comb begin
        w_lfsr_nxt = r_lfsr;
        if (i_load) begin
            w_lfsr_nxt = PRBS7_SEED;
        end else if (i_advance) begin
            w_lfsr_nxt = {r_lfsr[5:0],
                          r_lfsr[PRBS7_TAP_HI] ^ r_lfsr[PRBS7_TAP_LO]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr <= PRBS7_SEED;
        end else begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    assign o_bit_out = w_lfsr_nxt[PRBS7_TAP_HI];

endmodule

// File: rtl/probe_sequencer.sv
// Frame sequencer for the probe outputs: SQUARE burst, PRBS7 DATA burst, GAP.
// Config arrives through a one-deep shadow and is applied at frame starts.
module probe_sequencer
    import probe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [CNT_W-1:0] i_cfg_half_period,
    input  logic [CNT_W-1:0] i_cfg_burst_len,
    input  logic [CNT_W-1:0] i_cfg_gap_len,
    output logic             o_square_out,
    output logic             o_data_out,
    output logic             o_xor_out,
    output logic [1:0]       o_phase,
    output logic             o_frame_done
);

    phase_t           r_phase;
    phase_t           w_phase_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_sq_cnt;
    logic [CNT_W-1:0] w_sq_cnt_nxt;
    logic             r_square;
    logic             w_square_nxt;
    logic             r_data;
    logic             r_xor;
    logic             r_frame_done;
    logic             r_cfg_ready;

    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_burst;
    logic [CNT_W-1:0] r_gap;
    logic [CNT_W-1:0] r_sh_half;
    logic [CNT_W-1:0] r_sh_burst;
    logic [CNT_W-1:0] r_sh_gap;
    logic             r_sh_full;

    logic [CNT_W-1:0] w_half;
    logic [CNT_W-1:0] w_burst;
    logic [CNT_W-1:0] w_gap;
    logic [CNT_W-1:0] w_half_m1;
    logic             w_accept;
    logic             w_last;
    logic             w_start;
    logic             w_data_nxt;
    logic             w_done_nxt;
    logic             w_prbs_load;
    logic             w_prbs_adv;
    logic             w_prbs_bit;

    // Config a frame starting on this edge will run with.
    assign w_half  = r_sh_full ? r_sh_half  : r_half;
    assign w_burst = r_sh_full ? r_sh_burst : r_burst;
    assign w_gap   = r_sh_full ? r_sh_gap   : r_gap;

    assign w_half_m1 = (r_half == '0) ? '0 : r_half - 1'b1;
    assign w_accept  = i_cfg_valid && r_cfg_ready;

    assign w_last  = (r_phase == PH_GAP  && r_cnt == '0)
                  || (r_phase == PH_DATA && r_cnt == '0 && r_gap == '0);
    assign w_start = i_enable && (r_phase == PH_IDLE || w_last);

    always_comb begin
        w_phase_nxt  = r_phase;
        w_cnt_nxt    = r_cnt - 1'b1;
        w_sq_cnt_nxt = r_sq_cnt;
        w_square_nxt = 1'b0;
        unique case (r_phase)
            PH_IDLE: begin
                w_cnt_nxt = r_cnt;
            end
            PH_SQUARE: begin
                if (r_cnt == '0) begin
                    w_phase_nxt = PH_DATA;
                    w_cnt_nxt   = r_burst - 1'b1;
                end else if (r_sq_cnt == '0) begin
                    w_square_nxt = !r_square;
                    w_sq_cnt_nxt = w_half_m1;
                end else begin
                    w_square_nxt = r_square;
                    w_sq_cnt_nxt = r_sq_cnt - 1'b1;
                end
            end
            PH_DATA: begin
                if (r_cnt == '0 && r_gap != '0) begin
                    w_phase_nxt = PH_GAP;
                    w_cnt_nxt   = r_gap - 1'b1;
                end
            end
            PH_GAP: begin
            end
        endcase
        if (w_last) begin
            w_phase_nxt = PH_IDLE;
            w_cnt_nxt   = '0;
        end
        if (w_start) begin
            if (w_burst == '0) begin
                w_phase_nxt = PH_GAP;
                w_cnt_nxt   = (w_gap == '0) ? '0 : w_gap - 1'b1;
            end else begin
                w_phase_nxt  = PH_SQUARE;
                w_cnt_nxt    = w_burst - 1'b1;
                w_sq_cnt_nxt = (w_half == '0) ? '0 : w_half - 1'b1;
                w_square_nxt = 1'b1;
            end
        end
    end

    assign w_prbs_load = (w_phase_nxt == PH_DATA) && (r_phase != PH_DATA);
    assign w_prbs_adv  = (w_phase_nxt == PH_DATA) && (r_phase == PH_DATA);
    assign w_data_nxt  = (w_phase_nxt == PH_DATA) && w_prbs_bit;

    // A zero gap moves the frame-done pulse onto the last DATA cycle.
    assign w_done_nxt = (w_phase_nxt == PH_GAP  && w_cnt_nxt == '0)
                     || (w_phase_nxt == PH_DATA && w_cnt_nxt == '0
                         && r_gap == '0);

    prbs7_gen u_prbs (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (w_prbs_load),
        .i_advance (w_prbs_adv),
        .o_bit_out (w_prbs_bit)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase      <= PH_IDLE;
            r_cnt        <= '0;
            r_sq_cnt     <= '0;
            r_square     <= 1'b0;
            r_data       <= 1'b0;
            r_xor        <= 1'b0;
            r_frame_done <= 1'b0;
            r_cfg_ready  <= 1'b1;
            r_half       <= CNT_W'(DEF_HALF_PERIOD);
            r_burst      <= CNT_W'(DEF_BURST_LEN);
            r_gap        <= CNT_W'(DEF_GAP_LEN);
            r_sh_half    <= '0;
            r_sh_burst   <= '0;
            r_sh_gap     <= '0;
            r_sh_full    <= 1'b0;
        end else begin
            r_phase      <= w_phase_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sq_cnt     <= w_sq_cnt_nxt;
            r_square     <= w_square_nxt;
            r_data       <= w_data_nxt;
            r_xor        <= w_square_nxt ^ w_data_nxt;
            r_frame_done <= w_done_nxt;
            r_cfg_ready  <= !(w_accept || r_sh_full);
            if (w_accept) begin
                r_sh_half  <= i_cfg_half_period;
                r_sh_burst <= i_cfg_burst_len;
                r_sh_gap   <= i_cfg_gap_len;
                r_sh_full  <= 1'b1;
            end
            if (w_start && r_sh_full) begin
                r_half    <= r_sh_half;
                r_burst   <= r_sh_burst;
                r_gap     <= r_sh_gap;
                r_sh_full <= 1'b0;
            end
        end
    end

    assign o_cfg_ready  = r_cfg_ready;
    assign o_square_out = r_square;
    assign o_data_out   = r_data;
    assign o_xor_out    = r_xor;
    assign o_phase      = r_phase;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_probe_sequencer.sv
// Directed bench for probe_sequencer: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them and checks xor on every cycle.
module tb_probe_sequencer;
    import probe_pkg::*;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_cfg_valid = 1'b0;
    logic [15:0] i_cfg_half_period = '0;
    logic [15:0] i_cfg_burst_len = '0;
    logic [15:0] i_cfg_gap_len = '0;
    logic        o_cfg_ready;
    logic        o_square_out;
    logic        o_data_out;
    logic        o_xor_out;
    logic [1:0]  o_phase;
    logic        o_frame_done;

    always #5 clk = ~clk;

    probe_sequencer #(.CNT_W(16)) dut (
        .i_clk             (clk),
        .i_reset           (i_reset),
        .i_enable          (i_enable),
        .i_cfg_valid       (i_cfg_valid),
        .o_cfg_ready       (o_cfg_ready),
        .i_cfg_half_period (i_cfg_half_period),
        .i_cfg_burst_len   (i_cfg_burst_len),
        .i_cfg_gap_len     (i_cfg_gap_len),
        .o_square_out      (o_square_out),
        .o_data_out        (o_data_out),
        .o_xor_out         (o_xor_out),
        .o_phase           (o_phase),
        .o_frame_done      (o_frame_done)
    );

    typedef struct {
        int         cyc;
        int         scn;
        int         stp;
        logic [1:0] ph;
        logic       sq;
        logic       dt;
        logic       fd;
        logic       chkr;
        logic       rdy;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   cyc = 0;
    int   scn = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc > 0) begin
            n_chk++;
            if (o_xor_out !== (o_square_out ^ o_data_out)) begin
                n_err++;
                $display("FAIL xor cyc %0d: got %b want %b", cyc,
                         o_xor_out, o_square_out ^ o_data_out);
            end
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m_e = sb.pop_front();
            n_chk++;
            if (m_e.cyc != cyc) begin
                n_err++;
                $display("FAIL s%0d.%0d late: cyc %0d want %0d",
                         m_e.scn, m_e.stp, cyc, m_e.cyc);
            end else if (o_phase !== m_e.ph || o_square_out !== m_e.sq
                      || o_data_out !== m_e.dt
                      || o_frame_done !== m_e.fd
                      || (m_e.chkr && o_cfg_ready !== m_e.rdy)) begin
                n_err++;
                $display("FAIL s%0d.%0d outs: got ph=%0d sq=%b dt=%b fd=%b rdy=%b want ph=%0d sq=%b dt=%b fd=%b rdy=%b",
                         m_e.scn, m_e.stp, o_phase, o_square_out,
                         o_data_out, o_frame_done, o_cfg_ready,
                         m_e.ph, m_e.sq, m_e.dt, m_e.fd, m_e.rdy);
            end
        end
    end

    task automatic step(input logic en, input logic [1:0] ph,
                        input logic sq, input logic dt, input logic fd,
                        input logic chkr, input logic rdy, input int stp);
        exp_t e;
        i_enable = en;
        e.cyc  = cyc + 1;
        e.scn  = scn;
        e.stp  = stp;
        e.ph   = ph;
        e.sq   = sq;
        e.dt   = dt;
        e.fd   = fd;
        e.chkr = chkr;
        e.rdy  = rdy;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic cfg_idle(input logic [15:0] h, input logic [15:0] b,
                            input logic [15:0] g);
        i_cfg_half_period = h;
        i_cfg_burst_len   = b;
        i_cfg_gap_len     = g;
        i_cfg_valid       = 1'b1;
        step(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 100);
        i_cfg_valid = 1'b0;
        step(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 101);
    endtask

    // cfg_at: step that raises cfg_valid (caller preset the fields);
    // afterwards junk fields stay offered. drop_at: step that drops valid.
    task automatic frame(input int burst, input int gap,
                         input logic [15:0] sqp, input logic [15:0] dtp,
                         input logic en_mid, input logic rdy1,
                         input int cfg_at, input int drop_at);
        int n;
        n = 2 * burst + gap;
        for (int i = 1; i <= n; i++) begin
            logic [1:0] ph;
            logic       sq;
            logic       dt;
            logic       r;
            logic       en;
            if (i == drop_at) i_cfg_valid = 1'b0;
            if (cfg_at != 0 && i == cfg_at) i_cfg_valid = 1'b1;
            if (cfg_at != 0 && i == cfg_at + 1) begin
                i_cfg_half_period = 16'd5;
                i_cfg_burst_len   = 16'd9;
                i_cfg_gap_len     = 16'd9;
            end
            if (i <= burst) begin
                ph = PH_SQUARE;
                sq = sqp[burst - i];
                dt = 1'b0;
            end else if (i <= 2 * burst) begin
                ph = PH_DATA;
                sq = 1'b0;
                dt = dtp[2 * burst - i];
            end else begin
                ph = PH_GAP;
                sq = 1'b0;
                dt = 1'b0;
            end
            if (cfg_at != 0 && i >= cfg_at) r = 1'b0;
            else if (i == 1) r = rdy1;
            else r = 1'b1;
            en = (i == 1) || en_mid || (i <= burst + 1);
            step(en, ph, sq, dt, i == n, 1'b1, r, i);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        scn = 1;
        step(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        step(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        i_reset = 1'b0;
        step(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3);

        scn = 2;
        frame(16, 16, 16'hAAAA, 16'hFE04, 1'b1, 1'b1, 0, 0);
        step(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);

        scn = 3;
        cfg_idle(16'd3, 16'd12, 16'd2);
        frame(12, 2, 16'hE38, 16'hFE0, 1'b1, 1'b0, 0, 0);
        scn = 4;
        i_cfg_half_period = 16'd2;
        i_cfg_burst_len   = 16'd4;
        i_cfg_gap_len     = 16'd3;
        frame(12, 2, 16'hE38, 16'hFE0, 1'b1, 1'b1, 5, 0);
        frame(4, 3, 16'hC, 16'hF, 1'b1, 1'b0, 0, 3);
        frame(4, 3, 16'hC, 16'hF, 1'b1, 1'b1, 0, 0);
        scn = 5;
        frame(4, 3, 16'hC, 16'hF, 1'b0, 1'b1, 0, 0);
        step(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);

        scn = 6;
        cfg_idle(16'd1, 16'd0, 16'd4);
        frame(0, 4, 16'h0, 16'h0, 1'b1, 1'b0, 0, 0);
        frame(0, 4, 16'h0, 16'h0, 1'b1, 1'b1, 0, 0);
        step(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);

        scn = 7;
        cfg_idle(16'd1, 16'd0, 16'd0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, PH_GAP, 1'b0, 1'b0, 1'b1, 1'b1, i != 1, i);
        end
        step(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6);

        scn = 8;
        cfg_idle(16'd1, 16'd8, 16'd2);
        step(1'b1, PH_SQUARE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        i_cfg_half_period = 16'd2;
        i_cfg_burst_len   = 16'd3;
        i_cfg_gap_len     = 16'd5;
        i_cfg_valid       = 1'b1;
        step(1'b1, PH_SQUARE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        step(1'b1, PH_SQUARE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3);
        i_cfg_valid = 1'b0;
        i_reset     = 1'b1;
        step(1'b1, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        i_reset = 1'b0;
        step(1'b1, PH_SQUARE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5);
        step(1'b1, PH_SQUARE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6);
        step(1'b1, PH_SQUARE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7);
        i_enable = 1'b0;

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
